// File: rtl/pixel_write_buffer.sv
// Two-entry pixel write combiner: FILL merges pixel pairs belonging to one 8-pair row segment,
// SEND presents a completed segment to memory as a single masked 256-bit burst.
module pixel_write_buffer (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_pixValid,
  output logic         o_pixReady,
  input  logic [31:0]  i_pixelPair,
  input  logic [8:0]   i_pairX,
  input  logic [8:0]   i_pairY,
  input  logic         i_wrL,
  input  logic         i_wrR,
  input  logic         i_flush,
  output logic         o_busy,
  output logic         o_memReq,
  input  logic         i_memAck,
  output logic [14:0]  o_memAddr,
  output logic [255:0] o_memData,
  output logic [15:0]  o_memMask
);

  logic         fill_valid_q, fill_valid_d;
  logic [14:0]  fill_tag_q, fill_tag_d;
  logic [255:0] fill_data_q, fill_data_d;
  logic [15:0]  fill_mask_q, fill_mask_d;
  logic         send_valid_q, send_valid_d;
  logic [14:0]  send_tag_q, send_tag_d;
  logic [255:0] send_data_q, send_data_d;
  logic [15:0]  send_mask_q, send_mask_d;
  logic         flush_pend_q, flush_pend_d;

  logic [14:0]  seg;
  logic [2:0]   lane;
  logic         wr_any, hit, miss;
  logic         send_ack, send_free;
  logic         pix_ready, accept, wr_merge, new_fill, move_out;
  logic [15:0]  ins_mask;
  logic [255:0] ins_bits, wr_data;
  logic [14:0]  mrg_tag;
  logic [255:0] mrg_data;
  logic [15:0]  mrg_mask;

  // Expand the per-pixel enables of the addressed lane into mask and data-bit enables.
  always_comb begin
    ins_mask = '0;
    ins_bits = '0;
    for (int l = 0; l < 8; l++) begin
      if (lane == l[2:0]) begin
        ins_mask[2*l]           = i_wrL;
        ins_mask[2*l+1]         = i_wrR;
        ins_bits[32*l +: 16]    = {16{i_wrL}};
        ins_bits[32*l+16 +: 16] = {16{i_wrR}};
      end
    end
  end

  always_comb begin
    seg       = {i_pairY, i_pairX[8:3]};
    lane      = i_pairX[2:0];
    wr_any    = i_wrL | i_wrR;
    hit       = fill_valid_q && (fill_tag_q == seg);
    // A pair with no enables never displaces FILL.
    miss      = fill_valid_q && !hit && wr_any;
    send_ack  = send_valid_q & i_memAck;
    send_free = ~send_valid_q | send_ack;
    pix_ready = ~flush_pend_q & ~(miss & ~send_free);
    accept    = i_pixValid & pix_ready;
    wr_merge  = accept & wr_any & ~miss;
    new_fill  = accept & miss;
    move_out  = fill_valid_q & send_free & ((&fill_mask_q) | flush_pend_q | new_fill);

    wr_data   = (fill_data_q & ~ins_bits) | ({8{i_pixelPair}} & ins_bits);
    mrg_tag   = fill_valid_q ? fill_tag_q : seg;
    mrg_data  = wr_merge ? wr_data : fill_data_q;
    mrg_mask  = (fill_valid_q ? fill_mask_q : 16'h0000) | (wr_merge ? ins_mask : 16'h0000);
  end

  always_comb begin
    fill_valid_d = fill_valid_q;
    fill_tag_d   = fill_tag_q;
    fill_data_d  = fill_data_q;
    fill_mask_d  = fill_mask_q;
    send_valid_d = send_valid_q;
    send_tag_d   = send_tag_q;
    send_data_d  = send_data_q;
    send_mask_d  = send_mask_q;
    flush_pend_d = i_flush | (flush_pend_q & fill_valid_q & ~move_out);

    if (send_ack) begin
      send_valid_d = 1'b0;
    end

    if (move_out) begin
      // A hit arriving on the move edge is merged into the outgoing segment.
      send_valid_d = 1'b1;
      send_tag_d   = mrg_tag;
      send_data_d  = mrg_data;
      send_mask_d  = mrg_mask;
      if (new_fill) begin
        fill_valid_d = 1'b1;
        fill_tag_d   = seg;
        fill_data_d  = wr_data;
        fill_mask_d  = ins_mask;
      end else begin
        fill_valid_d = 1'b0;
        fill_mask_d  = '0;
      end
    end else if (wr_merge) begin
      fill_valid_d = 1'b1;
      fill_tag_d   = mrg_tag;
      fill_data_d  = mrg_data;
      fill_mask_d  = mrg_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      fill_valid_q <= 1'b0;
      fill_tag_q   <= '0;
      fill_data_q  <= '0;
      fill_mask_q  <= '0;
      send_valid_q <= 1'b0;
      send_tag_q   <= '0;
      send_data_q  <= '0;
      send_mask_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      fill_valid_q <= fill_valid_d;
      fill_tag_q   <= fill_tag_d;
      fill_data_q  <= fill_data_d;
      fill_mask_q  <= fill_mask_d;
      send_valid_q <= send_valid_d;
      send_tag_q   <= send_tag_d;
      send_data_q  <= send_data_d;
      send_mask_q  <= send_mask_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    o_pixReady = pix_ready;
    o_busy     = fill_valid_q | send_valid_q | flush_pend_q;
    o_memReq   = send_valid_q;
    o_memAddr  = send_tag_q;
    o_memData  = send_data_q;
    o_memMask  = send_mask_q;
  end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed and randomized bench for pixel_write_buffer; bursts are replayed into a model memory
// and compared against an image built straight from the accepted pixel writes.
module tb_pixel_write_buffer;

  logic         clk = 1'b0;
  logic         rst, pix_valid, pix_ready, wr_l, wr_r, flush, busy, mem_req, mem_ack;
  logic         man_ack, rand_ack, rand_en;
  logic [31:0]  pair;
  logic [8:0]   px, py;
  logic [14:0]  mem_addr;
  logic [255:0] mem_data;
  logic [15:0]  mem_mask;

  always #5 clk = ~clk;

  assign mem_ack = rand_en ? rand_ack : man_ack;
  always @(negedge clk) rand_ack <= ($urandom_range(0, 2) != 0);

  pixel_write_buffer dut (
    .clk         (clk),
    .i_rst       (rst),
    .i_pixValid  (pix_valid),
    .o_pixReady  (pix_ready),
    .i_pixelPair (pair),
    .i_pairX     (px),
    .i_pairY     (py),
    .i_wrL       (wr_l),
    .i_wrR       (wr_r),
    .i_flush     (flush),
    .o_busy      (busy),
    .o_memReq    (mem_req),
    .i_memAck    (mem_ack),
    .o_memAddr   (mem_addr),
    .o_memData   (mem_data),
    .o_memMask   (mem_mask)
  );

  typedef struct {
    logic [14:0]  addr;
    logic [15:0]  mask;
    logic [255:0] data;
  } burst_t;

  burst_t      bq[$];
  logic [15:0] tb_mem  [0:3][0:63];
  logic [15:0] ref_mem [0:3][0:63];

  // Memory side: capture every consumed burst and apply it to a small pixel image.
  always @(posedge clk) begin
    if (!rst && mem_req && mem_ack) begin
      bq.push_back('{addr: mem_addr, mask: mem_mask, data: mem_data});
      for (int k = 0; k < 16; k++) begin
        if (mem_mask[k] && mem_addr[14:6] < 9'd4 && mem_addr[5:0] < 6'd4) begin
          tb_mem[mem_addr[7:6]][mem_addr[5:0] * 16 + k] <= mem_data[16*k +: 16];
        end
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [8:0] x, input logic [8:0] y, input logic l, input logic r,
                     input logic [31:0] d);
    int n;
    @(negedge clk);
    px = x; py = y; wr_l = l; wr_r = r; pair = d; pix_valid = 1'b1;
    #1;
    n = 0;
    while (!pix_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!pix_ready) chk("put_accept_timeout", pix_ready, 1'b1);
    if (y < 9'd4 && x < 9'd32) begin
      if (l) ref_mem[y[1:0]][2*x]   = d[15:0];
      if (r) ref_mem[y[1:0]][2*x+1] = d[31:16];
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 50) begin
      chk({tag, "_busy"}, busy, 1'b1);
      @(negedge clk);
      n++;
    end
    chk(tag, mem_req, 1'b1);
  endtask

  initial begin
    int           base;
    logic [255:0] exp_d;
    logic [31:0]  d, da, db, dc;
    logic [14:0]  s_addr;
    logic [255:0] s_data;
    logic [15:0]  s_mask;
    logic [8:0]   rx, ry;

    rst = 1'b1; pix_valid = 1'b0; wr_l = 1'b0; wr_r = 1'b0; flush = 1'b0;
    pair = '0; px = '0; py = '0; man_ack = 1'b0; rand_en = 1'b0;
    for (int y = 0; y < 4; y++) for (int p = 0; p < 64; p++) tb_mem[y][p] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", pix_ready, 1'b1);
    chk("rst_mask", mem_mask, 16'h0);
    chk("rst_addr", mem_addr, 15'h0);
    chk("rst_data", mem_data, 256'h0);
    @(negedge clk);
    rst = 1'b0;

    // Pair with no enables leaves everything empty.
    put(9'd5, 9'd7, 1'b0, 1'b0, 32'hdeadbeef);
    chk("noop_busy", busy, 1'b0);

    // Full segment, ack tied high.
    man_ack = 1'b1;
    base = bq.size();
    exp_d = '0;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      exp_d[32*i +: 32] = d;
      put(9'(16 + i), 9'd5, 1'b1, 1'b1, d);
    end
    chk("full_no_early_req", mem_req, 1'b0);
    @(posedge clk);
    #1;
    chk("full_req", mem_req, 1'b1);
    repeat (3) @(negedge clk);
    chk("full_count", bq.size() - base, 1);
    chk("full_addr", bq[base].addr, {9'd5, 6'd2});
    chk("full_mask", bq[base].mask, 16'hffff);
    chk("full_data", bq[base].data, exp_d);
    chk("full_idle", busy, 1'b0);

    // Miss with SEND empty keeps ready high.
    man_ack = 1'b0;
    base = bq.size();
    da = $urandom;
    put(9'd0, 9'd0, 1'b1, 1'b0, da);
    @(negedge clk);
    px = 9'd8; py = 9'd0; wr_l = 1'b1; wr_r = 1'b1; pair = $urandom; pix_valid = 1'b1;
    #1;
    chk("miss_ready", pix_ready, 1'b1);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    man_ack = 1'b1;
    do_flush();
    wait_idle("miss_idle");
    chk("miss_count", bq.size() - base, 2);
    chk("miss_addr0", bq[base].addr, 15'd0);
    chk("miss_mask0", bq[base].mask, 16'h0001);
    chk("miss_data0", bq[base].data[15:0], da[15:0]);
    chk("miss_addr1", bq[base+1].addr, 15'd1);
    chk("miss_mask1", bq[base+1].mask, 16'h0003);

    // Three segments with ack low: third pair stalls until an ack.
    man_ack = 1'b0;
    base = bq.size();
    da = $urandom; db = $urandom; dc = $urandom;
    put(9'd0, 9'd1, 1'b1, 1'b1, da);
    put(9'd8, 9'd1, 1'b1, 1'b1, db);
    @(negedge clk);
    px = 9'd16; py = 9'd1; wr_l = 1'b1; wr_r = 1'b1; pair = dc; pix_valid = 1'b1;
    #1;
    s_addr = mem_addr; s_data = mem_data; s_mask = mem_mask;
    chk("stall_addr", mem_addr, {9'd1, 6'd0});
    for (int c = 0; c < 3; c++) begin
      chk("stall_ready", pix_ready, 1'b0);
      chk("stall_req", mem_req, 1'b1);
      chk("stall_stable", {mem_addr, mem_mask, s_data ^ mem_data}, {s_addr, s_mask, 256'h0});
      @(negedge clk);
      #1;
    end
    man_ack = 1'b1;
    #1;
    chk("stall_release", pix_ready, 1'b1);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    man_ack = 1'b0;
    chk("stall_next_addr", mem_addr, {9'd1, 6'd1});
    man_ack = 1'b1;
    do_flush();
    wait_idle("stall_idle");
    chk("stall_count", bq.size() - base, 3);
    chk("stall_b0", {bq[base].addr, bq[base].data[31:0]}, {9'd1, 6'd0, da});
    chk("stall_b1", {bq[base+1].addr, bq[base+1].data[31:0]}, {9'd1, 6'd1, db});
    chk("stall_b2", {bq[base+2].addr, bq[base+2].data[31:0]}, {9'd1, 6'd2, dc});

    // Same pixel overwritten before flush.
    base = bq.size();
    put(9'd3, 9'd2, 1'b1, 1'b0, 32'h0000_1234);
    put(9'd3, 9'd2, 1'b1, 1'b0, 32'h0000_5678);
    do_flush();
    wait_idle("ovr_idle");
    chk("ovr_count", bq.size() - base, 1);
    chk("ovr_addr", bq[base].addr, {9'd2, 6'd0});
    chk("ovr_mask", bq[base].mask, 16'h0040);
    chk("ovr_data", bq[base].data[96 +: 16], 16'h5678);

    // Flush with ack held low for four cycles.
    man_ack = 1'b0;
    base = bq.size();
    put(9'd40, 9'd3, 1'b1, 1'b1, $urandom);
    do_flush();
    chk("fl_busy_pend", busy, 1'b1);
    wait_req("fl_req");
    s_addr = mem_addr; s_data = mem_data; s_mask = mem_mask;
    for (int c = 0; c < 4; c++) begin
      chk("fl_busy_hold", busy, 1'b1);
      chk("fl_stable", {mem_req, mem_addr, mem_mask, s_data ^ mem_data},
          {1'b1, s_addr, s_mask, 256'h0});
      @(negedge clk);
    end
    man_ack = 1'b1;
    @(posedge clk);
    #1;
    man_ack = 1'b0;
    chk("fl_busy_after_ack", busy, 1'b0);
    chk("fl_addr", bq[base].addr, {9'd3, 6'd5});

    // Reset in the middle of an outstanding burst.
    put(9'd1, 9'd1, 1'b1, 1'b1, $urandom);
    do_flush();
    wait_req("mid_req");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_req", mem_req, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", pix_ready, 1'b1);
    chk("mid_rst_out", {mem_mask, mem_addr, mem_data}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Random traffic in a 4-row window with random ack.
    for (int y = 0; y < 4; y++) for (int p = 0; p < 64; p++) ref_mem[y][p] = tb_mem[y][p];
    rand_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rx = 9'($urandom_range(0, 31));
      ry = 9'($urandom_range(0, 3));
      put(rx, ry, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 15) == 0) do_flush();
    end
    do_flush();
    wait_idle("rand_idle");
    for (int y = 0; y < 4; y++) begin
      for (int p = 0; p < 64; p++) begin
        chk($sformatf("rand_pix_y%0d_p%0d", y, p), tb_mem[y][p], ref_mem[y][p]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_write_buffer.md
PIXEL_WRITE_BUFFER -- requirements
Module: pixel_write_buffer

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port i_pixValid, input, 1: a pixel pair is offered.
REQ-004 SHALL have port o_pixReady, output, 1: the offered pair is accepted this cycle when both valid and ready are high.
REQ-005 SHALL have port i_pixelPair, input, 32: {bit15_R,B_R,G_R,R_R,bit15_L,B_L,G_L,R_L}, shading/blend/dither stage output.
REQ-006 SHALL have port i_pairX, input, 9: pair index (screen X / 2).
REQ-007 SHALL have port i_pairY, input, 9: screen row.
REQ-008 SHALL have ports i_wrL and i_wrR, input, 1 each: per-pixel write enable.
REQ-009 SHALL have port i_flush, input, 1: close the open segment (end of primitive).
REQ-010 SHALL have port o_busy, output, 1: high while any buffered data is not yet acknowledged.
REQ-011 SHALL have port o_memReq, output, 1: burst write request.
REQ-012 SHALL have port i_memAck, input, 1: burst consumed.
REQ-013 SHALL have port o_memAddr, output, 15: {row[8:0], segment[5:0]}.
REQ-014 SHALL have port o_memData, output, 256: 8 pairs; pair i at bits [32i+31:32i].
REQ-015 SHALL have port o_memMask, output, 16: bit 2i = left pixel of pair i, bit 2i+1 = right pixel.

Function
REQ-016 SHALL hold two buffers: FILL (collecting) and SEND (presented to memory), each with valid flag, 15-bit tag, 256-bit data, 16-bit mask.
REQ-017 SHALL define the segment of a pair as {i_pairY, i_pairX[8:3]} and the lane as i_pairX[2:0].
REQ-018 SHALL treat an accepted pair with i_wrL=i_wrR=0 as a no-op: no tag change, no mask change.
REQ-019 SHALL, on an accepted hit (FILL valid, tag equal) or an accepted pair into an empty FILL, write only the enabled 16-bit halves of the lane, OR the enables into the mask, and load the tag when FILL was empty.
REQ-020 SHALL let a later write to the same pixel overwrite the earlier one.
REQ-021 SHALL, on a miss (FILL valid, tag differs) with SEND empty or being acknowledged this cycle, move FILL to SEND and start a new FILL with the incoming pair, in the same cycle.
REQ-022 SHALL drive o_pixReady low only on a miss while SEND is valid and i_memAck is low, or while a flush is pending.
REQ-023 SHALL, when FILL mask is all ones and SEND is free, move FILL to SEND on the next edge.
REQ-024 SHALL latch i_flush as a pending flag, cleared once FILL is empty or has been moved to SEND.
REQ-025 SHALL drive o_memReq = SEND valid, with o_memAddr/o_memData/o_memMask stable while o_memReq is high and i_memAck is low.
REQ-026 SHALL empty SEND on the edge where o_memReq and i_memAck are both high; a move from FILL into SEND is allowed on that same edge.
REQ-027 SHALL ignore i_memAck while o_memReq is low.
REQ-028 SHALL drive o_busy = FILL valid | SEND valid | flush pending.
REQ-029 SHALL respond with latency of zero cycles from acceptance to buffer state, with an accepted pair visible on o_memReq no earlier than the next edge after its move to SEND.

Reset
REQ-030 SHALL, while i_rst is high at an edge, clear both valid flags, both masks and flush pending, giving o_memReq=0, o_busy=0, o_pixReady=1, o_memMask=0, o_memAddr=0, o_memData=0.
REQ-031 SHALL, when reset is asserted mid-burst, drop outstanding data without waiting for i_memAck.

Verification
REQ-032 SHALL be covered by this case: 8 pairs at Y=5, X=16..23, both enables set, memAck tied high -> exactly one request with addr={5,2}, mask=FFFF, lane i data = pair i.
REQ-033 SHALL be covered by this case: pair X=0, Y=0 with wrL only, then X=8, Y=0 -> first burst addr 0, mask 0001; o_pixReady stays high because SEND was empty.
REQ-034 SHALL be covered by this case: memAck held low, three pairs in distinct segments -> third pair stalled (o_pixReady=0) until memAck pulses; no data lost or reordered.
REQ-035 SHALL be covered by this case: same pixel written with 0x1234 then 0x5678 before flush -> burst carries 0x5678 with its mask bit set once.
REQ-036 SHALL be covered by this case: single pair then i_flush with memAck low for 4 cycles -> o_busy=1 throughout, o_memReq stable, o_busy=0 the cycle after ack.
REQ-037 SHALL be covered by this case: i_rst asserted while o_memReq=1 -> next cycle o_memReq=0, o_busy=0, o_pixReady=1.
